// File: rtl/iob_aclint_pkg.sv
// Shared register offsets, reset values and helpers for the ACLINT.
package iob_aclint_pkg;

    localparam int unsigned MTIME_W = 64;

    // Byte offsets of the register regions (low two bits are always zero)
    localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;

    localparam logic [MTIME_W-1:0] MTIMECMP_RST = {MTIME_W{1'b1}};

    // Register targeted by the current bus address
    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    // Replace only the bytes whose strobe is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wr,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wr[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_aclint_tick.sv
// Tick source for mtime: synchronised rt_clk rising edge or clk prescaler.
module iob_aclint_tick #(
    parameter int USE_RTC  = 1,
    parameter int PRESCALE = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rt_clk,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [2:0]       rt_sync;
    logic [CNT_W-1:0] pre_cnt;
    logic             rt_edge;
    logic             pre_wrap;

    // Two synchroniser flops followed by one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rt_sync <= '0;
        else        rt_sync <= {rt_sync[1:0], rt_clk};
    end

    assign rt_edge  = rt_sync[1] & ~rt_sync[2];
    assign pre_wrap = (pre_cnt == CNT_MAX);

    // Free-running divider counting 0..PRESCALE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pre_cnt <= '0;
        else if (pre_wrap) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (USE_RTC != 0) ? rt_edge : pre_wrap;

endmodule

// File: rtl/iob_aclint.sv
// Core-local interruptor: mtime, per-hart mtimecmp/msip, tear-free mtime read.
module iob_aclint
    import iob_aclint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int N_CORES  = 1,
    parameter int USE_RTC  = 1,
    parameter int PRESCALE = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rt_clk,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CORES-1:0]  mtip,
    output logic [N_CORES-1:0]  msip
);

    logic               tick;
    logic [MTIME_W-1:0] mtime;
    logic [MTIME_W-1:0] mtimecmp [N_CORES];
    logic [31:0]        shadow_hi;
    logic               snap_vld;

    logic               accept;
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        word_addr;
    logic [31:0]        msip_off;
    logic [31:0]        cmp_off;
    reg_sel_e           sel;
    logic [5:0]         hart;
    logic [31:0]        rdata_nxt;

    iob_aclint_tick #(
        .USE_RTC  (USE_RTC),
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .rt_clk (rt_clk),
        .tick   (tick)
    );

    assign accept    = valid & ~ready;
    assign wr_en     = accept & (|wstrb);
    assign rd_en     = accept & ~(|wstrb);
    assign word_addr = 32'(address) & ~32'h3;
    assign msip_off  = word_addr - MSIP_BASE;
    assign cmp_off   = word_addr - MTIMECMP_BASE;

    // Address decode; harts beyond N_CORES fall through to REG_NONE
    always_comb begin
        sel  = REG_NONE;
        hart = '0;
        if (msip_off < 32'(4 * N_CORES)) begin
            sel  = REG_MSIP;
            hart = msip_off[7:2];
        end else if (word_addr >= MTIMECMP_BASE && cmp_off < 32'(8 * N_CORES)) begin
            sel  = cmp_off[2] ? REG_CMP_HI : REG_CMP_LO;
            hart = cmp_off[8:3];
        end else if (word_addr == MTIME_LO) begin
            sel = REG_MTIME_LO;
        end else if (word_addr == MTIME_HI) begin
            sel = REG_MTIME_HI;
        end
    end

    // Read mux; high mtime word comes from the snapshot when one is pending
    always_comb begin
        rdata_nxt = '0;
        case (sel)
            REG_MSIP: begin
                for (int h = 0; h < N_CORES; h++)
                    if (hart == 6'(h)) rdata_nxt = {31'b0, msip[h]};
            end
            REG_CMP_LO: begin
                for (int h = 0; h < N_CORES; h++)
                    if (hart == 6'(h)) rdata_nxt = mtimecmp[h][31:0];
            end
            REG_CMP_HI: begin
                for (int h = 0; h < N_CORES; h++)
                    if (hart == 6'(h)) rdata_nxt = mtimecmp[h][63:32];
            end
            REG_MTIME_LO: rdata_nxt = mtime[31:0];
            REG_MTIME_HI: rdata_nxt = snap_vld ? shadow_hi : mtime[63:32];
            default:      rdata_nxt = '0;
        endcase
    end

    // One-cycle ready pulse per accepted request, read data registered alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= accept;
            if (accept) rdata <= rd_en ? rdata_nxt : '0;
        end
    end

    // Software interrupt bits; only byte lane 0 carries the writable bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= '0;
        end else begin
            for (int h = 0; h < N_CORES; h++)
                if (wr_en && sel == REG_MSIP && hart == 6'(h) && wstrb[0])
                    msip[h] <= wdata[0];
        end
    end

    // Per-hart compare registers with byte-granular writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < N_CORES; h++) mtimecmp[h] <= MTIMECMP_RST;
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (wr_en && hart == 6'(h)) begin
                    if (sel == REG_CMP_LO)
                        mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
                    else if (sel == REG_CMP_HI)
                        mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
                end
            end
        end
    end

    // mtime counter; a bus write in a tick cycle suppresses the increment entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mtime <= '0;
        else if (wr_en && sel == REG_MTIME_LO)
            mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wstrb);
        else if (wr_en && sel == REG_MTIME_HI)
            mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
        else if (tick)
            mtime <= mtime + 64'd1;
    end

    // Low-word read captures the high word so a following high read is consistent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hi <= '0;
            snap_vld  <= 1'b0;
        end else if (rd_en && sel == REG_MTIME_LO) begin
            shadow_hi <= mtime[63:32];
            snap_vld  <= 1'b1;
        end else if ((rd_en || wr_en) && sel == REG_MTIME_HI) begin
            snap_vld  <= 1'b0;
        end else if (wr_en && sel == REG_MTIME_LO) begin
            snap_vld  <= 1'b0;
        end
    end

    // Registered timer interrupt per hart, unsigned 64-bit compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < N_CORES; h++) mtip[h] <= (mtime >= mtimecmp[h]);
        end
    end

endmodule

// File: doc/iob_aclint.md
# iob_aclint

Parametrised core-local interruptor, successor to the single-mode CLINT. Holds a 64-bit `mtime` counter, per-hart `mtimecmp` and `msip` registers behind the IOb native bus, and drives per-hart `mtip`/`msip` to the CPU cores. Additions over the previous generation:

- selectable tick source: synchronised `rt_clk` edge or an internal `clk` prescaler;
- writable `mtime`;
- tear-free 64-bit `mtime` read over a 32-bit bus.

## Interface
- `ADDR_W`, 16, byte-address width.
- `DATA_W`, 32, bus width; only 32 is supported.
- `N_CORES`, 1, hart count, 1..64.
- `USE_RTC`, 1, 1 = tick on `rt_clk` rising edge; 0 = tick every `PRESCALE` `clk` cycles.
- `PRESCALE`, 100, divider for `USE_RTC=0`, ≥1.
- `clk` in 1: system clock; the only clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rt_clk` in 1: asynchronous real-time clock; ignored when `USE_RTC=0`.
- `valid` in 1: request.
- `address` in `ADDR_W`: byte address; bits [1:0] are ignored.
- `wdata` in `DATA_W`: write data.
- `wstrb` in `DATA_W/8`: byte enables. All-zero means read.
- `rdata` out `DATA_W`: read data, meaningful while `ready`=1.
- `ready` out 1: response strobe.
- `mtip` out `N_CORES`: machine timer interrupt, one bit per hart.
- `msip` out `N_CORES`: machine software interrupt, one bit per hart.

## Operation

**Register map.** Offsets are held in the package.
- `0x0000 + 4*h`: `msip[h]`. Bit 0 is R/W; other bits read 0.
- `0x4000 + 8*h`: `mtimecmp[h]` low word. `+4` is the high word.
- `0xBFF8`: `mtime` low word. `0xBFFC`: `mtime` high word.
- Unmapped addresses and harts `h ≥ N_CORES`: read 0, writes ignored, `ready` still returned.

**Writes.**
- Honour `wstrb` per byte on every register.
- For `msip`, only `wstrb[0]` matters.

**Tick generation.**
- `USE_RTC=1`: `rt_clk` passes through a 2-flop synchroniser plus a third flop for edge detection. `tick` = synced & ~delayed.
- `USE_RTC=0`: a counter runs 0..`PRESCALE-1` and asserts `tick` in the cycle it wraps.

**`mtime`.**
- `tick` increments `mtime` by 1. It wraps 2^64-1 → 0.
- A bus write to `mtime` in the same cycle as `tick` wins: the written bytes are stored and there is no increment on any byte.

**Snapshot (tear-free read).**
- A read of `0xBFF8` returns live `mtime[31:0]`. It also latches `mtime[63:32]` into `shadow_hi` and sets `snap_vld`.
- A read of `0xBFFC` returns `shadow_hi` if `snap_vld`=1, else live `mtime[63:32]`. It always clears `snap_vld`.
- Any write to `mtime` clears `snap_vld`.

**Interrupts.**
- `mtip[h]` is registered: `mtime >= mtimecmp[h]`, unsigned 64-bit compare.
- `msip[h]` is the register bit, driven directly.

## Timing
- **Reset values:**
  - `mtime`=0, `mtimecmp[*]`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `mtip`=0;
  - `ready`=0, `rdata`=0;
  - prescaler=0, synchroniser flops=0, `snap_vld`=0, `shadow_hi`=0.
- **Handshake:**
  - A request is accepted when `valid`=1 and `ready`=0.
  - `ready` is asserted for exactly one cycle on the next edge, with `rdata` registered in that same edge.
  - A master holding `valid` high gets one response every 2 cycles.
  - Write side effects take effect at the acceptance edge.
- **`mtime` latency:**
  - `USE_RTC=1`: an `rt_clk` rising edge reaches `mtime` 3–4 `clk` cycles later.
  - `rt_clk` must be slower than `clk`/2; faster edges may be lost.
- **`mtip` latency:** 1 cycle after `mtime` or `mtimecmp` changes. A compare-register write that deasserts the condition drops `mtip` on the edge after the write.
- **Reset mid-transaction:** async clear; any in-flight response is dropped and `ready`=0 immediately.

## Structure
- Package `iob_aclint_pkg`:
  - offsets `MSIP_BASE`, `MTIMECMP_BASE`, `MTIME_LO`, `MTIME_HI`;
  - `MTIME_W`=64;
  - `MTIMECMP_RST`.
- Sub-module `iob_aclint_tick`: synchroniser, edge detect and prescaler, selected by `USE_RTC`. Output is a single-cycle `tick`.
- Top: register file, bus decode, snapshot logic, comparators.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-request → `ready`=0, `mtip`=0, `msip`=0. Read `0x4000` → `0xFFFFFFFF`. Read `0xBFF8` → 0.
2. **Software interrupt:** write `0x0000`=1 with `N_CORES`=2 → `msip`=2'b01 at the acceptance edge. Write 0 → clears. Write to `0x0008` → no change, `ready` returned.
3. **Timer, `USE_RTC=0`, `PRESCALE`=4:** set `mtimecmp[0]`=5 → `mtip[0]` rises exactly 1 cycle after `mtime` reaches 5, i.e. after 20 `clk` cycles from reset plus 1. Write `mtimecmp[0]`=100 → `mtip[0]` falls next cycle.
4. **Snapshot:** write `mtime`=`0x0000_0000_FFFF_FFFE`, then let 3 ticks occur between the low and high reads. Low read `0xFFFFFFFE` must pair with high read `0x00000000`, not 1. A following high read alone returns live 1.
5. **Collision and wrap:** write `mtime` low byte via `wstrb`=4'b0001 in a tick cycle → written value held with no increment. Set `mtime`=2^64-1, tick → 0.
6. **`USE_RTC=1`:** drive a 10-cycle-period `rt_clk` for 8 periods → `mtime`=8. Each increment lands 3–4 `clk` cycles after its `rt_clk` edge.
